// File: rtl/snoop_responder.sv
// Bus-side snoop responder for the MESI cache model: looks up the snooped set,
// returns HIT/HITM/NOHIT, writes back modified lines and updates the MESI state.
module snoop_responder #(
    parameter int ways     = 8,
    parameter int TAG_W    = 12,
    parameter int INDEX_W  = 14,
    parameter int OFFSET_W = 6,
    parameter int WAY_W    = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snoop_valid,
    output logic                   snoop_ready,
    input  logic [3:0]             snoop_cmd,
    input  logic [31:0]            snoop_addr,
    output logic                   lookup_en,
    output logic [INDEX_W-1:0]     lookup_index,
    input  logic [ways*TAG_W-1:0]  lookup_tag,
    input  logic [ways*2-1:0]      lookup_mesi,
    output logic                   update_en,
    output logic [WAY_W-1:0]       update_way,
    output logic [1:0]             update_mesi,
    output logic                   wb_req,
    output logic [31:0]            wb_addr,
    input  logic                   wb_ack,
    output logic                   result_valid,
    output logic [1:0]             snoop_result,
    output logic                   protocol_err
);

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    localparam logic [1:0]  RES_HIT   = 2'b00;
    localparam logic [1:0]  RES_HITM  = 2'b01;
    localparam logic [1:0]  RES_NOHIT = 2'b10;
    localparam logic [3:0]  CMD_INV   = 4'd3;
    localparam logic [3:0]  CMD_READ  = 4'd4;
    localparam logic [3:0]  CMD_WRITE = 4'd5;
    localparam logic [3:0]  CMD_RWIM  = 4'd6;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    state_t             state_q, state_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         result_q, result_d;
    logic [WAY_W-1:0]   way_q, way_d;
    mesi_t              next_mesi_q, next_mesi_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;

    logic [TAG_W-1:0]   addr_tag;
    logic [ways-1:0]    way_match;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    mesi_t              hit_mesi;
    logic               cmd_supported;

    logic [1:0]         dec_result;
    logic               dec_wb;
    logic               dec_upd;
    mesi_t              dec_next;
    logic               dec_err;

    assign addr_tag      = addr_q[OFFSET_W+INDEX_W +: TAG_W];
    assign cmd_supported = (snoop_cmd == CMD_INV) || (snoop_cmd == CMD_READ) ||
                           (snoop_cmd == CMD_WRITE) || (snoop_cmd == CMD_RWIM);

    // A way only counts as a hit when it holds a valid (non-I) copy of the tag.
    for (genvar gi = 0; gi < ways; gi++) begin : g_match
        assign way_match[gi] = (lookup_mesi[gi*2 +: 2] != MESI_I) &&
                               (lookup_tag[gi*TAG_W +: TAG_W] == addr_tag);
    end

    // Scan from the top so the lowest matching way is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_mesi = MESI_I;
        for (int w = ways - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_mesi = mesi_t'(lookup_mesi[w*2 +: 2]);
            end
        end
    end

    always_comb begin
        dec_result = RES_NOHIT;
        dec_wb     = 1'b0;
        dec_upd    = 1'b0;
        dec_next   = MESI_I;
        dec_err    = 1'b0;
        if (hit) begin
            case (cmd_q)
                CMD_READ: begin
                    dec_result = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    dec_wb     = (hit_mesi == MESI_M);
                    dec_upd    = (hit_mesi != MESI_S);
                    dec_next   = MESI_S;
                end
                CMD_RWIM: begin
                    dec_result = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    dec_wb     = (hit_mesi == MESI_M);
                    dec_upd    = 1'b1;
                    dec_next   = MESI_I;
                end
                CMD_INV: begin
                    // Another cache invalidating a line we own exclusively is illegal.
                    dec_result = RES_HIT;
                    dec_upd    = (hit_mesi == MESI_S);
                    dec_err    = (hit_mesi != MESI_S);
                    dec_next   = MESI_I;
                end
                CMD_WRITE: begin
                    dec_err    = 1'b1;
                end
                default: begin
                    dec_result = RES_NOHIT;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        result_d     = result_q;
        way_d        = way_q;
        next_mesi_d  = next_mesi_q;
        upd_d        = upd_q;
        err_d        = err_q;
        snoop_ready  = 1'b0;
        lookup_en    = 1'b0;
        lookup_index = '0;
        update_en    = 1'b0;
        update_way   = '0;
        update_mesi  = '0;
        wb_req       = 1'b0;
        wb_addr      = '0;
        result_valid = 1'b0;
        snoop_result = '0;
        protocol_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                snoop_ready = 1'b1;
                if (snoop_valid) begin
                    cmd_d  = snoop_cmd;
                    addr_d = snoop_addr;
                    if (cmd_supported) begin
                        lookup_en    = 1'b1;
                        lookup_index = snoop_addr[OFFSET_W +: INDEX_W];
                        state_d      = ST_LOOKUP;
                    end else begin
                        result_d = RES_NOHIT;
                        upd_d    = 1'b0;
                        err_d    = 1'b0;
                        state_d  = ST_RESPOND;
                    end
                end
            end
            ST_LOOKUP: begin
                result_d    = dec_result;
                way_d       = hit_way;
                next_mesi_d = dec_next;
                upd_d       = dec_upd;
                err_d       = dec_err;
                state_d     = dec_wb ? ST_WRITEBACK : ST_RESPOND;
            end
            ST_WRITEBACK: begin
                wb_req  = 1'b1;
                wb_addr = addr_q & LINE_MASK;
                if (wb_ack) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                result_valid = 1'b1;
                snoop_result = result_q;
                update_en    = upd_q;
                if (upd_q) begin
                    update_way  = way_q;
                    update_mesi = next_mesi_q;
                end
                protocol_err = err_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences every output immediately, whatever operation was underway.
        if (rst) begin
            state_d      = ST_IDLE;
            snoop_ready  = 1'b0;
            lookup_en    = 1'b0;
            lookup_index = '0;
            update_en    = 1'b0;
            update_way   = '0;
            update_mesi  = '0;
            wb_req       = 1'b0;
            wb_addr      = '0;
            result_valid = 1'b0;
            snoop_result = '0;
            protocol_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            result_q    <= '0;
            way_q       <= '0;
            next_mesi_q <= MESI_I;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            result_q    <= result_d;
            way_q       <= way_d;
            next_mesi_q <= next_mesi_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

endmodule
